// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and legality helper shared by the ALU files
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_MFHI  = 4'b1100;
  localparam logic [3:0] ALU_MFLO  = 4'b1101;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
  function automatic logic is_legal(input logic [3:0] c);
    return c inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_MULT,
                     ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO};
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes
// Ports: clk, rst (sync, active-high); start_i loads operands (is_div_i selects divide,
// sgn_i selects signed); done_o is high in the cycle of the last iteration, with
// hi_o/lo_o carrying the sign-corrected final {hi,lo} that the top latches on that edge.
module muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  logic               run_q, div_q, negp_q, negr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, m_q, hi_d, lo_d, mag_a, mag_b;
  logic [WIDTH:0]     sum, rem_t;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  // hi_q is the running partial product (mul) or partial remainder (div);
  // lo_q shifts the multiplier out (mul) or the dividend out / quotient in (div)
  always_comb begin
    mag_a  = sgn_i && a_i[WIDTH-1] ? -a_i : a_i;
    mag_b  = sgn_i && b_i[WIDTH-1] ? -b_i : b_i;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rem_t  = {hi_q, lo_q[WIDTH-1]};
    ge     = rem_t >= {1'b0, m_q};
    hi_d   = div_q ? (ge ? rem_t[WIDTH-1:0] - m_q : rem_t[WIDTH-1:0]) : sum[WIDTH:1];
    lo_d   = div_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    prod   = negp_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    hi_o   = div_q ? (negr_q ? -hi_d : hi_d) : prod[2*WIDTH-1:WIDTH];
    lo_o   = div_q ? (negp_q ? -lo_d : lo_d) : prod[WIDTH-1:0];
    done_o = run_q && cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      negp_q <= 1'b0;
      negr_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      div_q  <= is_div_i;
      negp_q <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      negr_q <= sgn_i & a_i[WIDTH-1];
      cnt_q  <= CNT_W'(WIDTH - 1);
      hi_q   <= '0;
      lo_q   <= is_div_i ? mag_a : mag_b;
      m_q    <= is_div_i ? mag_b : mag_a;
    end else if (run_q) begin
      run_q  <= cnt_q != '0;
      cnt_q  <= cnt_q - CNT_W'(1);
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered single-cycle ALU plus iterative mul/div writing HI/LO
// Ports: clk, rst (sync, active-high); valid_in/control/a/b request, accepted when
// ready_out is high; valid_out pulses with result, zero, hi, lo, div_by_zero, illegal_op.
// Define ALU_OVERFLOW_EN to add the overflow output for signed add/sub.
module alu_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             div_by_zero,
  output logic             illegal_op
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q, lo_q, sc_res, it_hi, it_lo;
  logic             valid_q, dbz_q, ill_q, accept, is_mul, is_dv, b_zero, start, it_done;
  always_comb begin
    accept = valid_in && state_q == ST_IDLE;
    is_mul = control == ALU_MULT || control == ALU_MULTU;
    is_dv  = control == ALU_DIV || control == ALU_DIVU;
    b_zero = b == '0;
    start  = accept && (is_mul || (is_dv && !b_zero));
    sc_res = control == ALU_ADD  ? a + b :
             control == ALU_SUB  ? a - b :
             control == ALU_AND  ? a & b :
             control == ALU_OR   ? a | b :
             control == ALU_SLT  ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
             control == ALU_SLTU ? {{(WIDTH-1){1'b0}}, a < b} :
             control == ALU_MFHI ? hi_q :
             control == ALU_MFLO ? lo_q : '0;
  end
  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .start_i(start), .is_div_i(is_dv),
    .sgn_i(control == ALU_MULT || control == ALU_DIV), .a_i(a), .b_i(b),
    .done_o(it_done), .hi_o(it_hi), .lo_o(it_lo)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end
  // divide by zero skips the iterations and goes straight to DONE
  always_comb begin
    state_d = state_q == ST_IDLE ? (!accept ? ST_IDLE : is_mul ? ST_MUL :
                                    !is_dv ? ST_IDLE : b_zero ? ST_DONE : ST_DIV) :
              state_q == ST_DONE ? ST_IDLE : it_done ? ST_DONE : state_q;
  end
  always_comb begin
    ready_out   = state_q == ST_IDLE;
    valid_out   = valid_q;
    result      = result_q;
    zero        = valid_q && result_q == '0;
    hi          = hi_q;
    lo          = lo_q;
    div_by_zero = dbz_q;
    illegal_op  = ill_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
      if (accept && !is_mul && !is_dv) begin
        valid_q  <= 1'b1;
        result_q <= sc_res;
        ill_q    <= !is_legal(control);
      end else if (accept && is_dv && b_zero) begin
        valid_q  <= 1'b1;
        dbz_q    <= 1'b1;
        result_q <= '1;
        lo_q     <= '1;
        hi_q     <= a;
      end else if (it_done) begin
        valid_q  <= 1'b1;
        result_q <= it_lo;
        lo_q     <= it_lo;
        hi_q     <= it_hi;
      end
    end
  end
`ifdef ALU_OVERFLOW_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= accept && (control == ALU_ADD ?
                    a[WIDTH-1] == b[WIDTH-1] && sc_res[WIDTH-1] != a[WIDTH-1] :
                  control == ALU_SUB ?
                    a[WIDTH-1] != b[WIDTH-1] && sc_res[WIDTH-1] != a[WIDTH-1] : 1'b0);
  end
  assign overflow = ovf_q;
`endif
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized and directed checks of alu_muldiv against an arithmetic model
module tb_alu_muldiv;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst = 1, valid_in = 0;
  logic [3:0] control = 0;
  logic [W-1:0] a = 0, b = 0;
  logic ready_out, valid_out, zero, div_by_zero, illegal_op;
  logic [W-1:0] result, hi, lo;
`ifdef ALU_OVERFLOW_EN
  logic overflow;
`endif
  int checks = 0, failures = 0;
  logic [W-1:0] m_hi = 0, m_lo = 0, e_res, g_res, g_hi, g_lo;
  logic e_ill, e_dbz, e_ovf, g_zero, g_ill, g_dbz, g_ovf;
  int e_lat, g_lat;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .control(control), .a(a), .b(b),
    .ready_out(ready_out), .valid_out(valid_out), .result(result), .zero(zero),
    .hi(hi), .lo(lo),
`ifdef ALU_OVERFLOW_EN
    .overflow(overflow),
`endif
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  task automatic model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p, qv, rv;
    longint s;
    e_res = 0; e_ill = 0; e_dbz = 0; e_ovf = 0; e_lat = 1;
    case (c)
      ALU_ADD:  begin e_res = x + y; s = longint'($signed(x)) + longint'($signed(y)); e_ovf = s != longint'($signed(e_res)); end
      ALU_SUB:  begin e_res = x - y; s = longint'($signed(x)) - longint'($signed(y)); e_ovf = s != longint'($signed(e_res)); end
      ALU_AND:  e_res = x & y;
      ALU_OR:   e_res = x | y;
      ALU_SLT:  e_res = ($signed(x) < $signed(y)) ? 1 : 0;
      ALU_SLTU: e_res = (x < y) ? 1 : 0;
      ALU_MFHI: e_res = m_hi;
      ALU_MFLO: e_res = m_lo;
      ALU_MULT, ALU_MULTU: begin
        p = (c == ALU_MULT) ? 64'(longint'($signed(x)) * longint'($signed(y))) : {32'b0, x} * {32'b0, y};
        m_hi = p[63:32]; m_lo = p[31:0]; e_res = m_lo; e_lat = W + 1;
      end
      ALU_DIV, ALU_DIVU: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x; e_dbz = 1;
        end else begin
          if (c == ALU_DIV) begin
            qv = 64'(longint'($signed(x)) / longint'($signed(y)));
            rv = 64'(longint'($signed(x)) % longint'($signed(y)));
          end else begin
            qv = {32'b0, x} / {32'b0, y};
            rv = {32'b0, x} % {32'b0, y};
          end
          m_lo = qv[31:0]; m_hi = rv[31:0]; e_lat = W + 1;
        end
        e_res = m_lo;
      end
      default: e_ill = 1;
    endcase
  endtask

  task automatic do_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 100) begin @(negedge clk); n++; end
    model(c, x, y);
    valid_in = 1; control = c; a = x; b = y;
    @(negedge clk);
    valid_in = 0; control = 4'($urandom); a = $urandom; b = $urandom;
    g_lat = 1;
    while (!valid_out && g_lat < 100) begin @(negedge clk); g_lat++; end
    g_res = result; g_zero = zero; g_hi = hi; g_lo = lo; g_ill = illegal_op; g_dbz = div_by_zero;
`ifdef ALU_OVERFLOW_EN
    g_ovf = overflow;
`else
    g_ovf = 0;
`endif
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset;
    checks++;
    if ({ready_out, valid_out, result, hi, lo, div_by_zero, illegal_op} !== {2'b10, 96'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset got rdy=%b vld=%b res=%h hi=%h lo=%h dbz=%b ill=%b exp rdy=1 rest 0",
               ready_out, valid_out, result, hi, lo, div_by_zero, illegal_op);
    end
  endtask

  task automatic test_single;
    logic [3:0] c[8] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_SUB, ALU_ADD};
    logic [W-1:0] x[8] = '{32'h7FFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'h0F00_0001, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] y[8] = '{1, 5, 1, 1, 32'h0FF0_FF00, 32'h0000_F0F0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(c[i], x[i], y[i]);
      checks += 4;
      if (g_lat !== e_lat) begin failures++; $display("FAIL single%0d lat got=%0d exp=%0d", i, g_lat, e_lat); end
      if ({g_res, g_zero, g_ill, g_dbz} !== {e_res, e_res == 0, e_ill, e_dbz}) begin
        failures++; $display("FAIL single%0d res got=%h z=%b exp=%h z=%b", i, g_res, g_zero, e_res, e_res == 0);
      end
      if ({g_hi, g_lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL single%0d hilo got=%h_%h exp=%h_%h", i, g_hi, g_lo, m_hi, m_lo); end
`ifdef ALU_OVERFLOW_EN
      if (g_ovf !== e_ovf) begin failures++; $display("FAIL single%0d ovf got=%b exp=%b", i, g_ovf, e_ovf); end
`else
      if (g_ovf !== 1'b0) begin failures++; $display("FAIL single%0d ovf got=%b exp=0", i, g_ovf); end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] r1, r2, res1, res2;
    logic v1, v2, rdy1;
    @(negedge clk);
    model(ALU_ADD, 32'h1234_5678, 32'h1111_1111); r1 = e_res;
    valid_in = 1; control = ALU_ADD; a = 32'h1234_5678; b = 32'h1111_1111;
    @(negedge clk);
    v1 = valid_out; res1 = result; rdy1 = ready_out;
    model(ALU_SUB, 32'h10, 32'h20); r2 = e_res;
    control = ALU_SUB; a = 32'h10; b = 32'h20;
    @(negedge clk);
    v2 = valid_out; res2 = result; valid_in = 0;
    checks += 2;
    if ({v1, rdy1, res1} !== {2'b11, r1}) begin failures++; $display("FAIL b2b_first got v=%b rdy=%b res=%h exp 1 1 %h", v1, rdy1, res1, r1); end
    if ({v2, res2} !== {1'b1, r2}) begin failures++; $display("FAIL b2b_second got v=%b res=%h exp 1 %h", v2, res2, r2); end
  endtask

  task automatic test_mult;
    do_op(ALU_MULT, -32'sd3, 32'd7);
    checks += 3;
    if (g_lat !== W + 1) begin failures++; $display("FAIL mult lat got=%0d exp=%0d", g_lat, W + 1); end
    if ({g_hi, g_lo, g_res} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB}) begin
      failures++; $display("FAIL mult hilo got=%h_%h res=%h exp=ffffffff_ffffffeb", g_hi, g_lo, g_res);
    end
    if ({g_hi, g_lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL mult model got=%h_%h exp=%h_%h", g_hi, g_lo, m_hi, m_lo); end
    do_op(ALU_MFLO, 0, 0);
    checks++;
    if ({g_lat, g_res} !== {32'd1, 32'hFFFF_FFEB}) begin failures++; $display("FAIL mflo got lat=%0d res=%h exp 1 ffffffeb", g_lat, g_res); end
    do_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({g_hi, g_lo, g_lat} !== {m_hi, m_lo, e_lat}) begin failures++; $display("FAIL multu got=%h_%h lat=%0d exp=%h_%h lat=%0d", g_hi, g_lo, g_lat, m_hi, m_lo, e_lat); end
  endtask

  task automatic test_div;
    logic [3:0] c[5] = '{ALU_DIV, ALU_DIVU, ALU_DIV, ALU_DIVU, ALU_DIV};
    logic [W-1:0] x[5] = '{-32'sd7, 7, 32'h8000_0000, 32'hFFFF_FFF0, 32'd100};
    logic [W-1:0] y[5] = '{2, 0, 32'hFFFF_FFFF, 32'd7, -32'sd9};
    for (int i = 0; i < 5; i++) begin
      do_op(c[i], x[i], y[i]);
      checks += 3;
      if (g_lat !== e_lat) begin failures++; $display("FAIL div%0d lat got=%0d exp=%0d", i, g_lat, e_lat); end
      if ({g_res, g_zero, g_ill, g_dbz} !== {e_res, e_res == 0, e_ill, e_dbz}) begin
        failures++; $display("FAIL div%0d res got=%h dbz=%b exp=%h dbz=%b", i, g_res, g_dbz, e_res, e_dbz);
      end
      if ({g_hi, g_lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL div%0d hilo got=%h_%h exp=%h_%h", i, g_hi, g_lo, m_hi, m_lo); end
    end
    do_op(ALU_DIV, -32'sd7, 2);
    checks++;
    if ({g_hi, g_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin failures++; $display("FAIL div_m7_2 got=%h_%h exp=ffffffff_fffffffd", g_hi, g_lo); end
  endtask

  task automatic test_backpressure;
    logic [3:0] cc;
    logic [W-1:0] xa, xb;
    int n, pulses;
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 100) begin @(negedge clk); n++; end
    model(ALU_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    valid_in = 1; control = ALU_MULTU; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    cc = ALU_MULTU; xa = 0; xb = 0; g_hi = 0; g_lo = 0;
    @(negedge clk);
    n = 1; pulses = 0;
    while (!ready_out && n < 100) begin
      if (valid_out) begin pulses++; g_hi = hi; g_lo = lo; end
      cc = n[0] ? ALU_AND : ALU_OR; xa = $urandom; xb = $urandom;
      control = cc; a = xa; b = xb;
      @(negedge clk); n++;
    end
    checks += 3;
    if (n !== W + 2) begin failures++; $display("FAIL bp_busy cycles got=%0d exp=%0d", n, W + 2); end
    if (pulses !== 1) begin failures++; $display("FAIL bp_pulses got=%0d exp=1", pulses); end
    if ({g_hi, g_lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL bp_multu got=%h_%h exp=%h_%h", g_hi, g_lo, m_hi, m_lo); end
    model(cc, xa, xb);
    @(negedge clk);
    valid_in = 0;
    checks++;
    if ({valid_out, result} !== {1'b1, e_res}) begin failures++; $display("FAIL bp_accept got v=%b res=%h exp 1 %h", valid_out, result, e_res); end
  endtask

  task automatic test_illegal;
    logic [3:0] c[4] = '{4'b0011, 4'b0100, 4'b0101, 4'b1110};
    do_op(ALU_MULT, 32'h0001_2345, 32'hFFF0_0001);
    for (int i = 0; i < 4; i++) begin
      do_op(c[i], $urandom, $urandom);
      checks += 2;
      if ({g_lat, g_res, g_zero, g_ill, g_dbz} !== {32'd1, 32'd0, 3'b110}) begin
        failures++; $display("FAIL illegal%0d got lat=%0d res=%h ill=%b exp 1 0 1", i, g_lat, g_res, g_ill);
      end
      if ({g_hi, g_lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL illegal%0d hilo got=%h_%h exp=%h_%h", i, g_hi, g_lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_random;
    logic [3:0] ops[14] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_MULT,
                            ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO, 4'b0011, 4'b1110};
    logic [3:0] c;
    for (int i = 0; i < 40; i++) begin
      c = ops[$urandom_range(0, 13)];
      do_op(c, rnd_val(), rnd_val());
      checks += 3;
      if (g_lat !== e_lat) begin failures++; $display("FAIL rand%0d op=%b lat got=%0d exp=%0d", i, c, g_lat, e_lat); end
      if ({g_res, g_zero, g_ill, g_dbz} !== {e_res, e_res == 0, e_ill, e_dbz}) begin
        failures++; $display("FAIL rand%0d op=%b res got=%h z=%b ill=%b dbz=%b exp=%h z=%b ill=%b dbz=%b",
                             i, c, g_res, g_zero, g_ill, g_dbz, e_res, e_res == 0, e_ill, e_dbz);
      end
      if ({g_hi, g_lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL rand%0d op=%b hilo got=%h_%h exp=%h_%h", i, c, g_hi, g_lo, m_hi, m_lo); end
`ifdef ALU_OVERFLOW_EN
      checks++;
      if (g_ovf !== e_ovf) begin failures++; $display("FAIL rand%0d ovf got=%b exp=%b", i, g_ovf, e_ovf); end
`endif
    end
  endtask

  task automatic test_reset_mid;
    int n, pulses;
    do_op(ALU_MULTU, 32'hFFFF_0000, 32'h0000_FFFF);
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 100) begin @(negedge clk); n++; end
    valid_in = 1; control = ALU_MULT; a = 32'h1357_9BDF; b = 32'h2468_ACE0;
    @(negedge clk);
    valid_in = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    m_hi = 0; m_lo = 0;
    checks++;
    if ({ready_out, valid_out, hi, lo} !== {2'b10, 64'b0}) begin
      failures++; $display("FAIL rst_mid got rdy=%b vld=%b hi=%h lo=%h exp 1 0 0 0", ready_out, valid_out, hi, lo);
    end
    pulses = 0;
    for (int i = 0; i < W + 8; i++) begin if (valid_out) pulses++; @(negedge clk); end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL rst_abort valid pulses got=%0d exp=0", pulses); end
    do_op(ALU_OR, 32'h00F0, 32'h0F00);
    checks++;
    if ({g_lat, g_res, g_hi, g_lo} !== {32'd1, 32'h0FF0, 64'b0}) begin
      failures++; $display("FAIL rst_after got lat=%0d res=%h hi=%h lo=%h exp 1 00000ff0 0 0", g_lat, g_res, g_hi, g_lo);
    end
  endtask

  initial begin
    rst = 1;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 0;
    test_single;
    test_back_to_back;
    test_mult;
    test_div;
    test_backpressure;
    test_illegal;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
